mult_share_arb4: RTL



---
 rtl/mult_share_arb4.sv | 111 +++++++++++
 1 files changed

// File: rtl/mult_share_arb4.sv
// mult_share_arb4: round-robin arbiter/sequencer sharing one 4x4 multiplier among four requesters
module mult_share_arb4 #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] a2,
  input  logic [3:0] a3,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  input  logic [3:0] b2,
  input  logic [3:0] b3,
  input  logic [7:0] mul_p,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       done,
  output logic [1:0] done_id,
  output logic [7:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, gnt_q, gnt_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [1:0] ptr_q, ptr_d, sel_q, sel_d, done_id_q, done_id_d, win, idx;
  logic [7:0] result_q, result_d;
  logic       done_q, done_d;
  logic [3:0] a_w, b_w;
  // Scan downward so the lowest offset from the pointer is the last (winning) assignment
  always_comb begin
    win = ptr_q;
    idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (req[idx]) win = idx;
    end
  end
  assign a_w = win == 2'd0 ? a0 : win == 2'd1 ? a1 : win == 2'd2 ? a2 : a3;
  assign b_w = win == 2'd0 ? b0 : win == 2'd1 ? b1 : win == 2'd2 ? b2 : b3;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    result_d  = result_q;
    done_id_d = done_id_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        sel_d   = win;
        gnt_d   = 4'b0001 << win;
        mul_a_d = a_w;
        mul_b_d = b_w;
        cnt_d   = 4'(LAT - 1);
        state_d = BUSY;
      end
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        result_d  = mul_p;
        done_d    = 1'b1;
        done_id_d = sel_q;
        state_d   = DONE;
      end
      DONE: begin
        gnt_d   = 4'd0;
        ptr_d   = sel_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      result_q  <= '0;
      done_id_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
      done_q    <= done_d;
    end
  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign sel     = sel_q;
  assign gnt     = gnt_q;
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
endmodule
